// File: rtl/nn_layer_sequencer_if.sv
// nn_layer_sequencer_if: control/status bundle between the layer sequencer and its environment
interface nn_layer_sequencer_if #(
    parameter int NUM_LAYERS = 3,
    parameter int LAYER_W    = 2,
    parameter int SAMPLE_W   = 10
);
    logic                  start;
    logic                  abort;
    logic                  calc_done;
    logic                  start_neuron;
    logic                  hidden;
    logic [NUM_LAYERS-2:0] ld_layer;
    logic [LAYER_W-1:0]    layer_idx;
    logic [SAMPLE_W-1:0]   sample_idx;
    logic                  batch_done;
    logic                  busy;
    logic                  done;

    modport slave (
        input  start, abort, calc_done,
        output start_neuron, hidden, ld_layer, layer_idx, sample_idx, batch_done, busy, done
    );

    modport master (
        output start, abort, calc_done,
        input  start_neuron, hidden, ld_layer, layer_idx, sample_idx, batch_done, busy, done
    );
endinterface

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: steps a batch of samples through hidden layers and an output layer
module nn_layer_sequencer #(
    parameter int NUM_LAYERS  = 3,
    parameter int NUM_SAMPLES = 750,
    parameter int LAYER_W     = 2,
    parameter int SAMPLE_W    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    nn_layer_sequencer_if.slave   io_bus
);
    typedef enum logic [1:0] {IDLE, FETCH, RUN, STEP} state_t;

    localparam int                  LW     = NUM_LAYERS - 1;
    localparam logic [LAYER_W-1:0]  LAST_L = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [SAMPLE_W-1:0] LAST_S = SAMPLE_W'(NUM_SAMPLES - 1);

    state_t              r_state, w_state_nx;
    logic [LAYER_W-1:0]  r_layer, w_layer_nx;
    logic [SAMPLE_W-1:0] r_sample, w_sample_nx;
    logic                w_hidden_nx;
    logic                r_start_neuron, r_hidden, r_batch_done, r_busy, r_done;
    logic [LW-1:0]       r_ld_layer;

    // next state and counters; abort outranks every non-IDLE transition
    always_comb begin
        w_state_nx  = r_state;
        w_layer_nx  = r_layer;
        w_sample_nx = r_sample;
        if (r_state == IDLE) begin
            if (io_bus.start) begin
                w_state_nx  = FETCH;
                w_layer_nx  = '0;
                w_sample_nx = '0;
            end
        end else if (io_bus.abort) begin
            w_state_nx  = IDLE;
            w_layer_nx  = '0;
            w_sample_nx = '0;
        end else if (r_state == FETCH) begin
            w_state_nx = RUN;
        end else if (r_state == RUN) begin
            w_state_nx = io_bus.calc_done ? STEP : RUN;
        end else if (r_layer < LAST_L) begin
            w_state_nx = RUN;
            w_layer_nx = r_layer + 1'b1;
        end else begin
            w_state_nx  = (r_sample == LAST_S) ? IDLE : FETCH;
            w_layer_nx  = '0;
            w_sample_nx = (r_sample == LAST_S) ? '0 : r_sample + 1'b1;
        end
    end

    assign w_hidden_nx = (w_state_nx == RUN) && (w_layer_nx < LAST_L);

    // state, counters and outputs registered together so outputs never see an input combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_layer        <= '0;
            r_sample       <= '0;
            r_start_neuron <= 1'b0;
            r_hidden       <= 1'b0;
            r_ld_layer     <= '0;
            r_batch_done   <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b1;
        end else begin
            r_state        <= w_state_nx;
            r_layer        <= w_layer_nx;
            r_sample       <= w_sample_nx;
            r_start_neuron <= w_state_nx == RUN;
            r_hidden       <= w_hidden_nx;
            r_ld_layer     <= w_hidden_nx ? LW'(1) << w_layer_nx : '0;
            r_batch_done   <= w_state_nx == FETCH;
            r_busy         <= w_state_nx != IDLE;
            r_done         <= w_state_nx == IDLE;
        end
    end

    assign io_bus.start_neuron = r_start_neuron;
    assign io_bus.hidden       = r_hidden;
    assign io_bus.ld_layer     = r_ld_layer;
    assign io_bus.layer_idx    = r_layer;
    assign io_bus.sample_idx   = r_sample;
    assign io_bus.batch_done   = r_batch_done;
    assign io_bus.busy         = r_busy;
    assign io_bus.done         = r_done;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: directed scenarios checked against a per-cycle behavioural model
module tb_nn_layer_sequencer;
    localparam int NL = 3;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nn_layer_sequencer_if #(.NUM_LAYERS(NL), .LAYER_W(2), .SAMPLE_W(2)) bus ();
    nn_layer_sequencer_if #(.NUM_LAYERS(2), .LAYER_W(1), .SAMPLE_W(1)) bus2 ();

    nn_layer_sequencer #(.NUM_LAYERS(NL), .NUM_SAMPLES(NS), .LAYER_W(2), .SAMPLE_W(2)) dut (
        .clk(clk), .rst(rst), .io_bus(bus)
    );
    nn_layer_sequencer #(.NUM_LAYERS(2), .NUM_SAMPLES(1), .LAYER_W(1), .SAMPLE_W(1)) dut2 (
        .clk(clk), .rst(rst), .io_bus(bus2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: where in the batch we are, as plain flags and integers
    bit m_busy = 0, m_fetch = 0, m_gap = 0;
    int m_layer = 0, m_sample = 0, m_runcyc = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 0; m_fetch = 0; m_gap = 0; m_layer = 0; m_sample = 0; m_runcyc = 0;
        end else if (!m_busy) begin
            if (bus.start) begin
                m_busy = 1; m_fetch = 1; m_gap = 0; m_layer = 0; m_sample = 0;
            end
        end else if (bus.abort) begin
            m_busy = 0; m_fetch = 0; m_gap = 0; m_layer = 0; m_sample = 0;
        end else if (m_fetch) begin
            m_fetch = 0; m_runcyc = 0;
        end else if (m_gap) begin
            m_gap = 0; m_runcyc = 0;
            if (m_layer < NL - 1) m_layer++;
            else begin
                m_layer = 0;
                if (m_sample == NS - 1) begin
                    m_busy = 0; m_sample = 0;
                end else begin
                    m_sample++; m_fetch = 1;
                end
            end
        end else if (bus.calc_done) m_gap = 1;
        else m_runcyc++;
    end

    function automatic logic [10:0] expect_out();
        logic run, hid;
        logic [1:0] ld;
        run = m_busy && !m_fetch && !m_gap;
        hid = run && (m_layer < NL - 1);
        ld  = hid ? 2'(1 << m_layer) : 2'b00;
        return {run, hid, ld, 2'(m_layer), 2'(m_sample), m_busy && m_fetch, m_busy, !m_busy};
    endfunction

    logic [10:0] dut_out;
    assign dut_out = {bus.start_neuron, bus.hidden, bus.ld_layer, bus.layer_idx,
                      bus.sample_idx, bus.batch_done, bus.busy, bus.done};

    bit chk_en = 0;
    initial forever begin
        @(negedge clk);
        if (chk_en) check("cycle", 32'(dut_out), 32'(expect_out()));
    end

    // calc_done stimulus: 0 off, 1 held high, 2 on 2nd RUN cycle, 3 = 2 plus spurious outside RUN
    int cd_mode = 0;
    initial begin
        bus.calc_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.calc_done = (cd_mode == 1)
                || (cd_mode >= 2 && m_busy && !m_fetch && !m_gap && m_runcyc == 1)
                || (cd_mode == 3 && !(m_busy && !m_fetch && !m_gap));
        end
    end

    int cyc = 0, busy_cnt = 0;
    logic prev_sn = 1'b0;
    int bd_s[$];
    int bd_t[$];
    logic [4:0] run_q[$];
    logic [4:0] run_exp [3] = '{5'b00101, 5'b01110, 5'b10000};
    logic [7:0] exp6 [6] = '{8'b00000110, 8'b11100010, 8'b00000010,
                             8'b10010010, 8'b00010010, 8'b00000001};

    initial forever begin
        @(negedge clk);
        cyc++;
        if (bus.busy) busy_cnt++;
        if (bus.batch_done) begin
            bd_s.push_back(int'(bus.sample_idx));
            bd_t.push_back(cyc);
        end
        if (bus.start_neuron && !prev_sn) run_q.push_back({bus.layer_idx, bus.hidden, bus.ld_layer});
        prev_sn = bus.start_neuron;
    end

    task automatic clear_rec();
        bd_s.delete(); bd_t.delete(); run_q.delete(); busy_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        @(negedge clk);
        while (!bus.done && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, " back to idle"}, 32'(bus.done), 32'd1);
    endtask

    task automatic check_batch(input string name, input int per_sample);
        check({name, " pulses"}, 32'(bd_s.size()), 32'd4);
        for (int i = 0; i < bd_s.size(); i++) check({name, " pulse sample"}, 32'(bd_s[i]), 32'(i));
        for (int i = 1; i < bd_t.size(); i++) check({name, " sample period"}, 32'(bd_t[i] - bd_t[i-1]), 32'(per_sample));
        check({name, " busy cycles"}, 32'(busy_cnt), 32'(4 * per_sample));
        check({name, " layer runs"}, 32'(run_q.size()), 32'd12);
        for (int i = 0; i < run_q.size(); i++) check({name, " layer/hidden/ld"}, 32'(run_q[i]), 32'(run_exp[i % 3]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus2.start = 1'b0; bus2.abort = 1'b0; bus2.calc_done = 1'b1;
        @(negedge clk);
        check("reset outputs", 32'(dut_out), 32'h001);
        check("reset dut2 done", 32'(bus2.done), 32'd1);
        @(negedge clk) rst = 1'b0;
        chk_en = 1;

        // 1: calc_done on the 2nd RUN cycle of every layer
        cd_mode = 2;
        clear_rec();
        pulse_start();
        wait_idle("s1", 200);
        check_batch("s1", 10);

        // 2: calc_done held high, one-cycle re-arm gaps
        cd_mode = 1;
        clear_rec();
        pulse_start();
        wait_idle("s2", 200);
        check_batch("s2", 7);

        // 3: abort with calc_done in RUN at layer 1, sample 2
        begin
            int n = 0;
            pulse_start();
            while (!(bus.start_neuron && bus.layer_idx == 2'd1 && bus.sample_idx == 2'd2) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("s3 abort window", 32'(n < 200), 32'd1);
            bus.abort = 1'b1;
            @(negedge clk) bus.abort = 1'b0;
            check("s3 after abort", 32'(dut_out), 32'h001);
            clear_rec();
            repeat (20) @(negedge clk);
            check("s3 no pulses after abort", 32'(bd_s.size()), 32'd0);
            cd_mode = 2;
            pulse_start();
            check("s3 restart fetch", 32'({bus.batch_done, bus.sample_idx}), 32'b100);
            wait_idle("s3", 200);
            check("s3 restart pulses", 32'(bd_s.size()), 32'd4);
        end

        // 4: spurious calc_done outside RUN, start+abort together in IDLE, start mid-batch
        cd_mode = 3;
        clear_rec();
        @(negedge clk) begin bus.start = 1'b1; bus.abort = 1'b1; end
        @(negedge clk) begin bus.start = 1'b0; bus.abort = 1'b0; end
        repeat (14) @(negedge clk);
        pulse_start();
        wait_idle("s4", 200);
        check_batch("s4", 10);

        // 5: asynchronous reset between clock edges during RUN
        cd_mode = 0;
        pulse_start();
        @(negedge clk);
        check("s5 in run", 32'(bus.start_neuron), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("s5 async reset", 32'(dut_out), 32'h001);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;

        // 6: two layers, one sample
        @(negedge clk) bus2.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) bus2.start = 1'b0;
            check("s6 trace", 32'({bus2.start_neuron, bus2.hidden, bus2.ld_layer, bus2.layer_idx,
                                   bus2.sample_idx, bus2.batch_done, bus2.busy, bus2.done}), 32'(exp6[i]));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
